sfx_scheduler: RTL

Voice scheduler for the sound mixer's sound-effect channels. It accepts play requests, allocates each to a free channel, and fetches one sample per active channel per sample period from a shared sample memory. It drives the mixer's packed `sfx` / `sfx_amp` buses, retiring channels when their sound ends. The background channel is outside this block.

---
 rtl/sfx_scheduler_pkg.sv | 19 +
 rtl/sfx_alloc.sv | 24 ++
 rtl/sfx_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sfx_scheduler_pkg.sv
// Shared sound types: sweep FSM states, mute attenuation, packed-bus slice helper.
// Used by the scheduler and the mixer so both agree on channel lane placement.
package sfx_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWEEP  = 2'd1,
      ST_COMMIT = 2'd2
   } sweep_state_t;

   localparam logic [3:0] AMP_MUTE = 4'hF;
   localparam int         CHAN_W   = 4;

   // Low bit of lane idx in a packed bus of width-bit lanes.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/sfx_alloc.sv
// Lowest-index free-channel priority encoder; purely combinational, zero latency.
// No backpressure of its own: free_vld low means every channel is busy.
module sfx_alloc
   import sfx_scheduler_pkg::*;
#(
   parameter int SOUNDS = 9
) (
   input  logic [SOUNDS-1:0] busy,
   output logic              free_vld,
   output logic [CHAN_W-1:0] free_chan
);

   always_comb begin
      free_vld  = 1'b0;
      free_chan = '0;
      for (int i = SOUNDS - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_vld  = 1'b1;
            free_chan = CHAN_W'(i);
         end
      end
   end

endmodule

// File: rtl/sfx_scheduler.sv
// Sfx voice scheduler: allocates play requests to channels and fetches one sample per busy channel per tick.
// Outputs update SOUNDS+2 cycles after a tick; req_ready drops when all channels are busy or stop_all is high.
module sfx_scheduler
   import sfx_scheduler_pkg::*;
#(
   parameter int BIT_DEPTH  = 8,
   parameter int SOUNDS     = 9,
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        sample_tick,
   input  logic                        stop_all,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_WIDTH-1:0]       req_addr,
   input  logic [LEN_WIDTH-1:0]        req_len,
   input  logic [3:0]                  req_amp,
   output logic [3:0]                  req_chan,
   output logic                        mem_rd,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   input  logic [BIT_DEPTH-1:0]        mem_data,
   output logic [SOUNDS*BIT_DEPTH-1:0] sfx,
   output logic [SOUNDS*4-1:0]         sfx_amp,
   output logic [SOUNDS-1:0]           busy,
   output logic                        overrun
);

   sweep_state_t state, state_nxt;

   logic [CHAN_W-1:0]     cnt;
   logic [SOUNDS-1:0]     busy_r;
   logic [SOUNDS-1:0]     mask;
   logic [ADDR_WIDTH-1:0] base    [SOUNDS];
   logic [LEN_WIDTH-1:0]  len     [SOUNDS];
   logic [LEN_WIDTH-1:0]  pos     [SOUNDS];
   logic [LEN_WIDTH-1:0]  pos_inc [SOUNDS];
   logic [3:0]            amp     [SOUNDS];
   logic [3:0]            out_amp [SOUNDS];
   logic [BIT_DEPTH-1:0]  shadow  [SOUNDS];
   logic [BIT_DEPTH-1:0]  out_smp [SOUNDS];
   logic                  rd_pend;
   logic [CHAN_W-1:0]     rd_chan;
   logic                  free_vld;
   logic [CHAN_W-1:0]     free_chan;
   logic                  accept;

   sfx_alloc #(.SOUNDS(SOUNDS)) u_alloc (
      .busy      (busy_r),
      .free_vld  (free_vld),
      .free_chan (free_chan)
   );

   assign req_ready = free_vld & ~stop_all;
   assign req_chan  = free_chan;
   assign accept    = req_valid & req_ready;
   assign busy      = busy_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      mem_addr  = '0;
      case (state)
         ST_IDLE: begin
            if (sample_tick) state_nxt = ST_SWEEP;
         end
         ST_SWEEP: begin
            if (mask[cnt]) begin
               mem_rd   = 1'b1;
               mem_addr = base[cnt] + ADDR_WIDTH'(pos[cnt]);
            end
            if (cnt == CHAN_W'(SOUNDS - 1)) state_nxt = ST_COMMIT;
         end
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (stop_all) begin
         state_nxt = ST_IDLE;
         mem_rd    = 1'b0;
      end
   end

   // Sweep counter, fetch mask and one-deep read-return tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         mask    <= '0;
         rd_pend <= 1'b0;
         rd_chan <= '0;
         overrun <= 1'b0;
      end else begin
         rd_pend <= mem_rd;
         rd_chan <= cnt;
         overrun <= sample_tick & ~stop_all & (state != ST_IDLE);
         if (stop_all) begin
            cnt <= '0;
         end else if (state == ST_IDLE && sample_tick) begin
            cnt  <= '0;
            mask <= busy_r;
         end else if (state == ST_SWEEP) begin
            cnt <= cnt + CHAN_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < SOUNDS; i++) pos_inc[i] = pos[i] + LEN_WIDTH'(1);
   end

   // Commit reads the last channel's sample straight off mem_data, since its shadow lands on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= '0;
         for (int i = 0; i < SOUNDS; i++) begin
            base[i]    <= '0;
            len[i]     <= '0;
            pos[i]     <= '0;
            amp[i]     <= AMP_MUTE;
            shadow[i]  <= '0;
            out_smp[i] <= '0;
            out_amp[i] <= AMP_MUTE;
         end
      end else if (stop_all) begin
         busy_r <= '0;
         for (int i = 0; i < SOUNDS; i++) begin
            pos[i]     <= '0;
            shadow[i]  <= '0;
            out_smp[i] <= '0;
            out_amp[i] <= AMP_MUTE;
         end
      end else begin
         for (int i = 0; i < SOUNDS; i++) begin
            if (rd_pend && rd_chan == CHAN_W'(i)) shadow[i] <= mem_data;
            if (state == ST_COMMIT) begin
               if (mask[i]) begin
                  out_smp[i] <= (rd_pend && rd_chan == CHAN_W'(i)) ? mem_data : shadow[i];
                  out_amp[i] <= amp[i];
                  pos[i]     <= pos_inc[i];
                  if (pos_inc[i] == len[i]) busy_r[i] <= 1'b0;
               end else begin
                  out_smp[i] <= '0;
                  out_amp[i] <= AMP_MUTE;
               end
            end
            if (accept && req_len != '0 && free_chan == CHAN_W'(i)) begin
               busy_r[i] <= 1'b1;
               base[i]   <= req_addr;
               len[i]    <= req_len;
               pos[i]    <= '0;
               amp[i]    <= req_amp;
            end
         end
      end
   end

   always_comb begin
      sfx     = '0;
      sfx_amp = '0;
      for (int i = 0; i < SOUNDS; i++) begin
         sfx[slice_lo(i, BIT_DEPTH) +: BIT_DEPTH] = out_smp[i];
         sfx_amp[slice_lo(i, 4) +: 4]             = out_amp[i];
      end
   end

endmodule
